// File: rtl/houghlines_accel_udiv_seq_19ns_9ns_10.sv
// Sequential restoring unsigned divider (19-bit / 9-bit -> saturated 10-bit quotient).
// One restoring step per ce-qualified edge, with valid/ready handshakes on both sides.
module houghlines_accel_udiv_seq_19ns_9ns_10 #(
    parameter int DIVIDEND_W = 19,
    parameter int DIVISOR_W  = 9,
    parameter int QUOT_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ovf,
    output logic                  dbz
);

    // state | meaning
    // IDLE  | waiting for an operand pair, in_ready=1
    // BUSY  | running DIVIDEND_W restoring steps
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] shreg;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W:0]    r;
    logic                  dbz_lat;

    logic                  accept, step, last_step, release_out;
    logic [DIVISOR_W:0]    r_shift, r_next;
    logic                  q_bit, ovf_next;
    logic [DIVIDEND_W-1:0] shreg_next;

    assign accept      = ce & in_valid & (state == IDLE);
    assign step        = ce & (state == BUSY);
    assign release_out = ce & out_ready & (state == DONE);
    assign last_step   = (cnt == CNT_W'(DIVIDEND_W - 1));

    // Dividend bits leave the top of shreg while quotient bits enter at the bottom,
    // so after the last step shreg holds the full-width quotient.
    assign r_shift    = {r[DIVISOR_W-1:0], shreg[DIVIDEND_W-1]};
    assign q_bit      = (r_shift >= {1'b0, dsr});
    assign r_next     = q_bit ? (r_shift - {1'b0, dsr}) : r_shift;
    assign shreg_next = {shreg[DIVIDEND_W-2:0], q_bit};
    assign ovf_next   = |shreg_next[DIVIDEND_W-1:QUOT_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                state_nxt = BUSY;
            BUSY:    if (step && last_step)     state_nxt = DONE;
            DONE:    if (release_out)           state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            shreg   <= '0;
            dsr     <= '0;
            r       <= '0;
            dbz_lat <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
        end else if (accept) begin
            shreg   <= dividend;
            dsr     <= divisor;
            dbz_lat <= (divisor == '0);
            r       <= '0;
            cnt     <= '0;
        end else if (step) begin
            r     <= r_next;
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
            if (last_step) begin
                quot <= ovf_next ? '1 : shreg_next[QUOT_W-1:0];
                rem  <= r_next[DIVISOR_W-1:0];
                ovf  <= ovf_next;
                dbz  <= dbz_lat;
            end
        end
    end

endmodule

// File: tb/tb_houghlines_accel_udiv_seq_19ns_9ns_10.sv
// Bench for the sequential divider: directed cases plus a random sweep against
// a plain-arithmetic reference model.
module tb_houghlines_accel_udiv_seq_19ns_9ns_10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [18:0] dividend = '0;
    logic [8:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  quot;
    logic [8:0]  rem;
    logic        ovf;
    logic        dbz;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    houghlines_accel_udiv_seq_19ns_9ns_10 dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, saturation and divide-by-zero rules.
    task automatic model(input int unsigned a, input int unsigned b,
                         output int unsigned e_quot, output int unsigned e_rem,
                         output int unsigned e_ovf, output int unsigned e_dbz);
        int unsigned tq;
        tq     = (b == 0) ? 32'h7FFFF : a / b;
        e_rem  = (b == 0) ? (a % 512) : (a % b);
        e_ovf  = (tq > 1023) ? 1 : 0;
        e_quot = e_ovf ? 1023 : tq;
        e_dbz  = (b == 0) ? 1 : 0;
    endtask

    // ce_toggle: alternate ce while busy; stall: cycles out_ready stays low after done.
    task automatic do_div(input string tag, input int unsigned a, input int unsigned b,
                          input bit ce_toggle, input int stall, input bit full_checks);
        int unsigned e_quot, e_rem, e_ovf, e_dbz;
        int edges, rise, guard;
        bit edge_ce;
        model(a, b, e_quot, e_rem, e_ovf, e_dbz);

        @(negedge clk);
        ce = 1'b1; out_ready = 1'b0;
        dividend = 19'(a); divisor = 9'(b); in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        edges = 0; rise = 0; guard = 0;
        while (rise == 0 && guard < 200) begin
            @(negedge clk);
            ce = ce_toggle ? ~ce : 1'b1;
            // Garbage on the inputs while busy must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            dividend = 19'($urandom);
            divisor  = 9'($urandom);
            edge_ce  = ce;
            @(posedge clk);
            #1;
            if (edge_ce) edges++;
            if (out_valid) rise = edges;
            guard++;
        end
        in_valid = 1'b0;
        if (full_checks) chk({tag, " latency"}, rise, 19);
        chk({tag, " quot"}, quot, e_quot);
        chk({tag, " rem"},  rem,  e_rem);
        chk({tag, " ovf"},  ovf,  e_ovf);
        chk({tag, " dbz"},  dbz,  e_dbz);
        if (full_checks) chk({tag, " in_ready busy-done"}, in_ready, 0);

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            ce = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, " stall out_valid"}, out_valid, 1);
            chk({tag, " stall in_ready"},  in_ready,  0);
            chk({tag, " stall quot"},      quot,      e_quot);
            chk({tag, " stall rem"},       rem,       e_rem);
        end

        @(negedge clk);
        ce = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (full_checks) begin
            chk({tag, " release out_valid"}, out_valid, 0);
            chk({tag, " release in_ready"},  in_ready,  1);
            chk({tag, " hold quot"},         quot,      e_quot);
        end
    endtask

    initial begin
        int unsigned a, b;
        int spurious;

        repeat (3) @(negedge clk);
        chk("reset in_ready",  in_ready,  1);
        chk("reset out_valid", out_valid, 0);
        chk("reset quot",      quot,      0);
        chk("reset rem",       rem,       0);
        chk("reset ovf",       ovf,       0);
        chk("reset dbz",       dbz,       0);
        reset = 1'b1;
        @(negedge clk);

        do_div("T1", 522753, 511, 1'b0, 0, 1'b1);
        do_div("T2", 100000, 7, 1'b0, 0, 1'b1);
        do_div("T3", 12345, 0, 1'b0, 0, 1'b1);
        do_div("T4", 522753, 511, 1'b1, 0, 1'b1);
        do_div("T5", 522753, 511, 1'b0, 10, 1'b1);

        // Frozen state: with ce low an offered operand must not be taken.
        @(negedge clk);
        ce = 1'b0; in_valid = 1'b1; dividend = 19'd50; divisor = 9'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("ce0 no accept", in_ready, 1);
        in_valid = 1'b0; ce = 1'b1;

        // T6: abort at iteration 7.
        @(negedge clk);
        dividend = 19'd522753; divisor = 9'd511; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("T6 abort out_valid", out_valid, 0);
        chk("T6 abort in_ready",  in_ready,  1);
        chk("T6 abort quot",      quot,      0);
        chk("T6 abort rem",       rem,       0);
        @(negedge clk);
        reset = 1'b1;
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        chk("T6 no spurious out_valid", spurious, 0);
        do_div("T6", 250, 3, 1'b0, 0, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            a = $urandom_range(0, 524287);
            b = $urandom_range(0, 511);
            case (i % 50)
                0: b = 1;
                1: a = 524287;
                2: begin a = 524287; b = 1; end
                3: b = 0;
                4: begin a = $urandom_range(0, 1023) * b; end
                default: ;
            endcase
            do_div("RND", a, b, 1'(i % 7 == 0), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
